// File: rtl/ssd1306_pkg.sv
// Shared opcodes, geometry defaults and decoder enums for the SSD1306 SPI sink.
package ssd1306_pkg;

    localparam int DEF_COLS  = 128;
    localparam int DEF_PAGES = 8;

    localparam logic [7:0] OP_SET_MODE = 8'h20;
    localparam logic [7:0] OP_SET_COL  = 8'h21;
    localparam logic [7:0] OP_SET_PAGE = 8'h22;
    localparam logic [7:0] OP_DISP_OFF = 8'hAE;
    localparam logic [7:0] OP_DISP_ON  = 8'hAF;

    typedef enum logic {MODE_HORZ, MODE_PAGE} mode_e;

    typedef enum logic [2:0] {
        IDLE, ARG_MODE, ARG_C0, ARG_C1, ARG_P0, ARG_P1, ARG_SKIP
    } dec_state_e;

    // Configuration commands that carry exactly one argument we do not model.
    function automatic logic is_skip_op(input logic [7:0] op);
        case (op)
            8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI mode-0 byte deserialiser: input synchronisers, sck edge detect, shift register.
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       dc,
    input  logic       oled_rst_n,
    output logic       byte_vld,
    output logic [7:0] rx_byte,
    output logic       byte_dc,
    output logic       panel_rst
);
    logic [1:0] sck_s, mosi_s, cs_s, dc_s, ors_s;
    logic       sck_d, cs_d;
    logic [7:0] shreg;
    logic [2:0] cnt;
    logic       full, dc_hold;
    logic       sck_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s  <= '0;
            mosi_s <= '0;
            dc_s   <= '0;
            cs_s   <= '1;
            ors_s  <= '1;
            sck_d  <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sck_s  <= {sck_s[0], sck};
            mosi_s <= {mosi_s[0], mosi};
            dc_s   <= {dc_s[0], dc};
            cs_s   <= {cs_s[0], cs_n};
            ors_s  <= {ors_s[0], oled_rst_n};
            sck_d  <= sck_s[1];
            cs_d   <= cs_s[1];
        end
    end

    assign sck_rise  = sck_s[1] & ~sck_d;
    assign panel_rst = ~ors_s[1];

    // Gating with the one-cycle-old chip select lets a byte whose last edge
    // coincides with cs_n rising still complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= '0;
            cnt      <= '0;
            full     <= 1'b0;
            dc_hold  <= 1'b0;
            byte_vld <= 1'b0;
            rx_byte  <= '0;
            byte_dc  <= 1'b0;
        end else if (panel_rst) begin
            shreg    <= '0;
            cnt      <= '0;
            full     <= 1'b0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= full;
            full     <= 1'b0;
            if (full) begin
                rx_byte <= shreg;
                byte_dc <= dc_hold;
            end
            if (sck_rise && !cs_d) begin
                shreg <= {shreg[6:0], mosi_s[1]};
                cnt   <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    full    <= 1'b1;
                    dc_hold <= dc_s[1];
                end
            end else if (cs_s[1]) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 SPI sink: decodes the addressing command subset into framebuffer writes.
// Define SSD1306_SPI_RX_PAGE_MODE_EN to enable page addressing mode and its commands.
module ssd1306_spi_rx
    import ssd1306_pkg::*;
#(
    parameter int COLS  = DEF_COLS,
    parameter int PAGES = DEF_PAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       dc,
    input  logic       oled_rst_n,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_data,
    output logic       disp_on,
    output logic       cmd_err
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);
    localparam int AW = 10;

    typedef struct packed {
        dec_state_e     st;
        mode_e          mode;
        logic [CW-1:0]  col, col_s, col_e;
        logic [PW-1:0]  page, page_s, page_e;
        logic           disp_on, cmd_err, we;
        logic [AW-1:0]  addr;
        logic [7:0]     data;
    } dec_t;

    localparam dec_t DEC_RST = '{
        st: IDLE, mode: MODE_HORZ,
        col: '0, col_s: '0, col_e: CW'(COLS - 1),
        page: '0, page_s: '0, page_e: PW'(PAGES - 1),
        disp_on: 1'b0, cmd_err: 1'b0, we: 1'b0, addr: '0, data: '0
    };

    logic       byte_vld, byte_dc, panel_rst;
    logic [7:0] b;
    dec_t       d;

    spi_byte_rx u_rx (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .dc        (dc),
        .oled_rst_n(oled_rst_n),
        .byte_vld  (byte_vld),
        .rx_byte   (b),
        .byte_dc   (byte_dc),
        .panel_rst (panel_rst)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d <= DEC_RST;
        end else if (panel_rst) begin
            d <= DEC_RST;
        end else begin
            d.we <= 1'b0;
            if (byte_vld && byte_dc) begin
                // Data always wins, even when a command was still waiting on arguments.
                d.st   <= IDLE;
                d.we   <= 1'b1;
                d.addr <= AW'(d.page) * AW'(COLS) + AW'(d.col);
                d.data <= b;
                if (d.mode == MODE_PAGE) begin
                    d.col <= (d.col == CW'(COLS - 1)) ? '0 : d.col + CW'(1);
                end else if (d.col == d.col_e) begin
                    d.col  <= d.col_s;
                    d.page <= (d.page == d.page_e) ? d.page_s : d.page + PW'(1);
                end else begin
                    d.col <= d.col + CW'(1);
                end
            end else if (byte_vld) begin
                case (d.st)
                    IDLE: begin
                        if (b == OP_DISP_OFF)      d.disp_on <= 1'b0;
                        else if (b == OP_DISP_ON)  d.disp_on <= 1'b1;
                        else if (b == OP_SET_MODE) d.st <= ARG_MODE;
                        else if (b == OP_SET_COL)  d.st <= ARG_C0;
                        else if (b == OP_SET_PAGE) d.st <= ARG_P0;
                        else if (is_skip_op(b))    d.st <= ARG_SKIP;
`ifdef SSD1306_SPI_RX_PAGE_MODE_EN
                        else if (b[7:3] == 5'b10110) d.page <= PW'(b[2:0]);
                        else if (b[7:4] == 4'h0)     d.col <= {d.col[CW-1:4], b[3:0]};
                        else if (b[7:4] == 4'h1)     d.col <= {b[CW-5:0], d.col[3:0]};
`endif
                    end
                    ARG_MODE: begin
                        d.st <= IDLE;
                        if (b[1:0] == 2'd0) d.mode <= MODE_HORZ;
`ifdef SSD1306_SPI_RX_PAGE_MODE_EN
                        else if (b[1:0] == 2'd2) d.mode <= MODE_PAGE;
`endif
                        else d.cmd_err <= 1'b1;
                    end
                    ARG_C0: begin
                        d.col_s <= b[CW-1:0];
                        d.col   <= b[CW-1:0];
                        d.st    <= ARG_C1;
                    end
                    ARG_C1: begin
                        d.col_e <= b[CW-1:0];
                        d.st    <= IDLE;
                    end
                    ARG_P0: begin
                        d.page_s <= b[PW-1:0];
                        d.page   <= b[PW-1:0];
                        d.st     <= ARG_P1;
                    end
                    ARG_P1: begin
                        d.page_e <= b[PW-1:0];
                        d.st     <= IDLE;
                    end
                    default: d.st <= IDLE;
                endcase
            end
        end
    end

    assign fb_we   = d.we;
    assign fb_addr = d.addr;
    assign fb_data = d.data;
    assign disp_on = d.disp_on;
    assign cmd_err = d.cmd_err;

endmodule

// File: doc/ssd1306_spi_rx.md
# ssd1306_spi_rx

SPI sink for the Arduboy OLED bus, sitting directly downstream of the Arduboy top's `ja` port (OLED CS, DC, reset, SCK, MOSI). It deserialises the SSD1306-style byte stream, decodes the addressing command subset, and emits one-cycle framebuffer write strobes with a linear byte address. It lets the bench and the display path observe frames without a physical panel.

## Interface
- `COLS`, 128: panel columns; column counter range 0..COLS-1.
- `PAGES`, 8: 8-pixel pages; page counter range 0..PAGES-1.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `sck` input 1: SPI clock from master, mode 0, asynchronous to `clk`.
- `mosi` input 1: SPI data, MSB first.
- `cs_n` input 1: chip select, active low.
- `dc` input 1: 0 = command byte, 1 = data byte.
- `oled_rst_n` input 1: panel reset from master, active low; asynchronous to `clk`.
- `fb_we` output 1: one-cycle write strobe.
- `fb_addr` output 10: page*COLS + column.
- `fb_data` output 8: data byte, bit0 = top pixel of the page.
- `disp_on` output 1: display on/off state.
- `cmd_err` output 1: sticky flag for an unsupported addressing mode; cleared by reset.

## Operation
- Synchroniser: `sck`, `mosi`, `cs_n`, `dc` and `oled_rst_n` each pass through 2 flops. Edge detection on `sck` compares the second synchroniser stage with a third flop.
- Deserialiser: on each synchronised `sck` rising edge with `cs_n` low, the block shifts in `mosi` and increments a 3-bit count. On the 8th bit it presents the byte, together with `dc` sampled on that edge.
  - `cs_n` high clears the bit count.
  - A partial byte is discarded.
- Decoder FSM states:
  - IDLE
  - ARG_MODE: one argument after 0x20.
  - ARG_C0 and ARG_C1: arguments after 0x21.
  - ARG_P0 and ARG_P1: arguments after 0x22.
  - ARG_SKIP: one argument discarded after 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA or 0xDB.
- Command bytes in IDLE:
  - 0xAE clears `disp_on`; 0xAF sets it.
  - 0x21 args: col_start, then col_end; column is set to col_start.
  - 0x22 args: page_start, then page_end; page is set to page_start.
  - Argument values are masked to the counter width.
  - Any other command byte is ignored, and the FSM stays in IDLE.
- A data byte arriving while the FSM is in an ARG state is treated as data, and the FSM returns to IDLE.
- Mode argument: [1:0]=0 selects horizontal; 2 selects page mode (see Configuration); 1 or 3 sets `cmd_err` and keeps the current mode.
- Data byte handling: assert `fb_we`, `fb_addr` = page*COLS+col and `fb_data` = byte, then advance the address.
  - Horizontal mode: if col==col_end, col becomes col_start and page advances (if page==page_end, page becomes page_start, else page+1); otherwise col+1.
  - Page mode: col+1, wrapping from COLS-1 to 0; page unchanged.
- Synchronised `oled_rst_n` low gives the same state as `rst`, except that the synchroniser flops keep running.
- An async `rst` mid-byte or mid-command drops everything.

## Timing
- Reset values:
  - Outputs: `fb_we`=0, `fb_addr`=0, `fb_data`=0, `disp_on`=0, `cmd_err`=0.
  - Internal state: FSM=IDLE, mode=horizontal, col=page=0, col_start=0, col_end=COLS-1, page_start=0, page_end=PAGES-1.
- Latency: `fb_we` is high exactly 4 `clk` cycles after the first `clk` edge that samples the 8th `sck` high.
  - `fb_addr` and `fb_data` are valid during that cycle and hold until the next strobe.
  - A command takes effect on the same cycle count, and applies to the next data byte.
- Input constraint: `sck` high and low each ≥3 `clk` periods. `mosi` and `dc` must be stable from 1 `clk` before to 3 `clk` after the `sck` rise.
- `cs_n` rising on the same cycle as the 8th edge: the byte is still delivered.
- Write rate is at most one strobe per 6 `clk` cycles, so no buffering is needed.

## Configuration
- `SSD1306_SPI_RX_PAGE_MODE_EN` defined: mode 2 selects page mode.
  - In IDLE, 0xB0–0xB7 set page = byte[2:0].
  - 0x00–0x0F set col[3:0]; 0x10–0x1F set col[6:4] = byte[2:0].
- Not defined: mode 2 sets `cmd_err` and keeps horizontal mode; 0x00–0x1F and 0xB0–0xB7 are ignored.

## Structure
- Package `ssd1306_pkg`:
  - Opcode constants (0x20, 0x21, 0x22, 0xAE, 0xAF, the skip list).
  - Mode enum {MODE_HORZ, MODE_PAGE}.
  - FSM state enum.
  - Default geometry constants.
- Sub-module `spi_byte_rx`: synchronisers, edge detect, shift register and bit count. Outputs `byte_vld` (1 cycle), `byte`, `byte_dc`, `panel_rst`.

## Test plan
- Reset, then `cs_n`=0, `dc`=1, bytes 0x5A, 0xA5 → two `fb_we` pulses: addr 0 data 0x5A, then addr 1 data 0xA5; `disp_on`=0.
- Commands 0x21,0x10,0x11 and 0x22,0x02,0x03, then 5 data bytes → addresses 272, 273, 400, 401, 272.
- Command 0xAF, then 0x81,0xFF, then data 0x01 → `disp_on`=1; 0xFF is not taken as a command; write goes to addr 0.
- 5 bits clocked, `cs_n` pulsed high, then full byte 0xC3 with `dc`=1 → single write of data 0xC3; no partial write.
- Command 0x20,0x01 → `cmd_err`=1, mode unchanged. With the macro: 0x20,0x02, 0xB3, 0x0F, 0x17, then data bytes until the column passes 127 → first address 3*128+127=511, next 384 (wrap in page).
- `oled_rst_n` low for 4 cycles mid-stream after 0x21,0x10,0x11 → the next data byte goes to addr 0.
